// File: rtl/req_ack_4ph_rx_mc.sv
// ---------------------------------------------------------------------------
// req_ack_4ph_rx_mc
//
// Multi-channel receiver for the 4-phase req/ack handshake.
//
// NCH independent senders each raise req[i] while holding din[i] stable. Each
// channel has the following pieces:
//   - its own req synchronizer
//   - a small handshake FSM (IDLE -> PEND -> ACKH -> IDLE)
//   - a holding register for the captured word
// A round-robin arbiter picks one PEND channel per cycle. It writes
// {channel id, data} into a shared output FIFO, which is read through a
// valid/ready interface.
//
// Optional feature (macro REQ_ACK_RX_ERR_EN):
//   Adds the sticky per-channel error flags err and the clear input err_clr.
//   A channel whose req drops while it is still PEND is abandoned and flagged.
//   When the macro is undefined, such a channel completes normally.
//
// Ports:
//   clk_rx    in   1                 receive-domain clock
//   rst       in   1                 synchronous active-high reset
//   req       in   NCH               per-channel request (asynchronous)
//   din       in   NCH*DW            per-channel data, channel i at [i*DW +: DW]
//   ack       out  NCH               per-channel acknowledge (registered)
//   err       out  NCH               sticky protocol-error flags (macro only)
//   err_clr   in   NCH               per-channel error clear (macro only)
//   out_val   out  1                 FIFO head valid
//   out_rdy   in   1                 consumer ready
//   out_data  out  DW                FIFO head data
//   out_ch    out  CW                FIFO head channel id
//   fifo_cnt  out  $clog2(DEPTH)+1   FIFO occupancy
// ---------------------------------------------------------------------------
module req_ack_4ph_rx_mc #(
  parameter int NCH          = 4,
  parameter int DW           = 8,
  parameter int DEPTH        = 4,
  parameter int SYNC_STAGES  = 2,
  localparam int CW          = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CNTW        = $clog2(DEPTH) + 1
) (
  input  logic              clk_rx,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] din,
  output logic [NCH-1:0]    ack,
`ifdef REQ_ACK_RX_ERR_EN
  output logic [NCH-1:0]    err,
  input  logic [NCH-1:0]    err_clr,
`endif
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_ch,
  output logic [CNTW-1:0]   fifo_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACKH = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [NCH-1:0]         req_s;
  state_t                 state  [NCH];
  logic [DW-1:0]          hold   [NCH];
  logic [NCH-1:0]         pend;

  logic [CW-1:0]          rr_start;
  logic                   grant_vld;
  logic [CW-1:0]          grant_idx;
  logic [CW-1:0]          grant_next;

  logic [CW+DW-1:0]       mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push;
  logic                   pop;

  // req synchronizers. Nothing else in the block looks at raw req.
  always_ff @(posedge clk_rx) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        sync_q[i] <= '0;
      end else begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req[i]};
      end
    end
  end

  always_comb begin
    req_s = '0;
    for (int i = 0; i < NCH; i++) begin
      req_s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // The arbiter sees a channel as eligible in two cases.
  // With error checking: only if the channel is PEND and req is still high.
  // Without it: whenever the channel is PEND, so a dropped req still
  // completes.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef REQ_ACK_RX_ERR_EN
      pend[i] = (state[i] == PEND) && req_s[i];
`else
      pend[i] = (state[i] == PEND);
`endif
    end
  end

  // Round-robin arbiter. rr_start holds the first channel to examine, which
  // is one past the last granted channel. It resets to 0, so channel 0 has
  // top priority after reset. A full FIFO blocks every grant, even when a pop
  // happens in the same cycle.
  always_comb begin
    logic [CW1-1:0] sum;
    logic [CW-1:0]  cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    if (fifo_cnt < CNTW'(DEPTH)) begin
      for (int k = 0; k < NCH; k++) begin
        sum = {1'b0, rr_start} + CW1'(k);
        if (sum >= CW1'(NCH)) begin
          sum = sum - CW1'(NCH);
        end
        cand = sum[CW-1:0];
        if (!grant_vld && pend[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Next search start after a grant: the granted index plus one, mod NCH.
  always_comb begin
    logic [CW1-1:0] nxt;
    nxt = {1'b0, grant_idx} + CW1'(1);
    if (nxt >= CW1'(NCH)) begin
      nxt = '0;
    end
    grant_next = nxt[CW-1:0];
  end

  assign push    = grant_vld;
  assign out_val = (fifo_cnt != '0);
  assign pop     = out_val && out_rdy;

  assign {out_ch, out_data} = mem[rd_ptr];

  // FIFO pointers, occupancy and RR pointer. DEPTH is a power of two, so the
  // pointers wrap naturally.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      rr_start <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        rr_start <= grant_next;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage. Stale contents are harmless, because out_val gates the
  // head.
  always_ff @(posedge clk_rx) begin
    if (push) begin
      mem[wr_ptr] <= {grant_idx, hold[grant_idx]};
    end
  end

  // Per-channel handshake FSMs. ack changes only on state transitions.
  // In the error build the clear is applied first, so that a set occurring
  // in the same cycle overrides it.
  always_ff @(posedge clk_rx) begin
    if (rst) begin
      ack <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        hold[i]  <= '0;
      end
`ifdef REQ_ACK_RX_ERR_EN
      err <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
`ifdef REQ_ACK_RX_ERR_EN
        err[i] <= err[i] & ~err_clr[i];
`endif
        case (state[i])
          IDLE: begin
            if (req_s[i]) begin
              hold[i]  <= din[i*DW +: DW];
              state[i] <= PEND;
            end
          end
          PEND: begin
`ifdef REQ_ACK_RX_ERR_EN
            if (!req_s[i]) begin
              state[i] <= IDLE;
              err[i]   <= 1'b1;
            end else
`endif
            if (grant_vld && (grant_idx == CW'(i))) begin
              ack[i]   <= 1'b1;
              state[i] <= ACKH;
            end
          end
          ACKH: begin
            if (!req_s[i]) begin
              ack[i]   <= 1'b0;
              state[i] <= IDLE;
            end
          end
          default: begin
            ack[i]   <= 1'b0;
            state[i] <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_req_ack_4ph_rx_mc.sv
// ---------------------------------------------------------------------------
// tb_req_ack_4ph_rx_mc
//
// Testbench for req_ack_4ph_rx_mc with NCH=8, DW=8, DEPTH=4, SYNC_STAGES=2.
//
// Directed sections cover the following, using constant expectations:
//   - reset values
//   - single-handshake latency
//   - round-robin order
//   - back-pressure
//   - simultaneous push and pop
//   - mid-operation reset
//   - protocol-violation handling
//
// A randomized section drives 4-phase senders on all channels against a
// random consumer. Every popped entry is checked against per-channel queues
// of the words the senders offered.
//
// The error-flag checks are built only when REQ_ACK_RX_ERR_EN is defined.
// ---------------------------------------------------------------------------
module tb_req_ack_4ph_rx_mc;

  localparam int NCH         = 8;
  localparam int DW          = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = 3;
  localparam int CNTW        = 3;

  logic              clk_rx = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    ack;
  logic              out_val;
  logic              out_rdy;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic [CNTW-1:0]   fifo_cnt;
`ifdef REQ_ACK_RX_ERR_EN
  logic [NCH-1:0]    err;
  logic [NCH-1:0]    err_clr;
`endif

  int check_count = 0;
  int error_count = 0;

  int            pop_ch_count [NCH];
  logic [DW-1:0] exp_q [NCH][$];
  int            phase [NCH];
  int            timer [NCH];
  int            seen_ch   [4];
  int            seen_data [4];
  int            seen_cyc  [4];

  req_ack_4ph_rx_mc #(
    .NCH         (NCH),
    .DW          (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_rx   (clk_rx),
    .rst      (rst),
    .req      (req),
    .din      (din),
    .ack      (ack),
`ifdef REQ_ACK_RX_ERR_EN
    .err      (err),
    .err_clr  (err_clr),
`endif
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_ch   (out_ch),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk_rx = ~clk_rx;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock. Inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] req_v, input logic rdy_v);
    req     = req_v;
    out_rdy = rdy_v;
  endtask

  task automatic setData(input int ch, input logic [DW-1:0] v);
    din[ch*DW +: DW] = v;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, 1'b0);
`ifdef REQ_ACK_RX_ERR_EN
    err_clr = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitAck(input logic [NCH-1:0] mask, input logic [NCH-1:0] value, input string tag);
    for (int n = 0; n < 60 && ((ack & mask) != value); n++) tick();
    checkOutput(tag, ack & mask, value);
  endtask

  task automatic waitCnt(input logic [CNTW-1:0] value, input string tag);
    for (int n = 0; n < 60 && (fifo_cnt != value); n++) tick();
    checkOutput(tag, fifo_cnt, value);
  endtask

  // Pops for a fixed number of cycles and tallies which channels emerge.
  task automatic drainFifo(input int cycles);
    for (int i = 0; i < NCH; i++) pop_ch_count[i] = 0;
    out_rdy = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (out_val) pop_ch_count[int'(out_ch)]++;
      tick();
    end
    out_rdy = 1'b0;
  endtask

  // Channels 0..3 request together. Entries must emerge in channel order on
  // consecutive cycles.
  task automatic collectRound(input logic [DW-1:0] base, input string tag);
    int got;
    for (int i = 0; i < 4; i++) setData(i, base + DW'(i));
    applyStimulus(8'h0F, 1'b1);
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (out_val) begin
        seen_ch[got]   = int'(out_ch);
        seen_data[got] = int'(out_data);
        seen_cyc[got]  = c;
        got++;
      end
      tick();
    end
    checkOutput({tag, "_count"}, got, 4);
    for (int j = 0; j < got; j++) begin
      checkOutput({tag, "_ch"},   seen_ch[j],   j);
      checkOutput({tag, "_data"}, seen_data[j], int'(base) + j);
      checkOutput({tag, "_cyc"},  seen_cyc[j] - seen_cyc[0], j);
    end
    waitAck(8'h0F, 8'h0F, {tag, "_ack_hi"});
    applyStimulus('0, 1'b1);
    waitAck(8'h0F, 8'h00, {tag, "_ack_lo"});
    out_rdy = 1'b0;
  endtask

  // One cycle of randomized traffic. Each sender follows the 4-phase
  // protocol, and popped entries are compared with the offered words in
  // per-channel order.
  task automatic randomCycle(input bit allow_new);
    logic [DW-1:0] v;
    out_rdy = ($urandom_range(0, 3) != 0);
    if (out_val && out_rdy) begin
      checkOutput("rnd_has_expect", exp_q[int'(out_ch)].size() != 0, 1);
      if (exp_q[int'(out_ch)].size() != 0) begin
        v = exp_q[int'(out_ch)].pop_front();
        checkOutput("rnd_data", out_data, v);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      case (phase[i])
        0: begin
          if (allow_new && !ack[i] && $urandom_range(0, 3) == 0) begin
            v = DW'($urandom);
            setData(i, v);
            exp_q[i].push_back(v);
            req[i]   = 1'b1;
            phase[i] = 1;
            timer[i] = 0;
          end
        end
        1: begin
          if (ack[i]) begin
            req[i]   = 1'b0;
            phase[i] = 2;
            timer[i] = 0;
          end else if (++timer[i] > 300) begin
            checkOutput("rnd_ack_rise_timeout", ack[i], 1);
            timer[i] = 0;
          end
        end
        default: begin
          if (!ack[i]) begin
            phase[i] = 0;
          end else if (++timer[i] > 300) begin
            checkOutput("rnd_ack_fall_timeout", ack[i], 0);
            timer[i] = 0;
          end
        end
      endcase
    end
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    din     = '0;
    out_rdy = 1'b0;
`ifdef REQ_ACK_RX_ERR_EN
    err_clr = '0;
`endif
    repeat (3) tick();
    checkOutput("reset_ack",      ack,      0);
    checkOutput("reset_out_val",  out_val,  0);
    checkOutput("reset_fifo_cnt", fifo_cnt, 0);
    rst = 1'b0;

    // Single handshake on channel 1.
    setData(1, 8'hA5);
    applyStimulus(8'h02, 1'b0);
    repeat (3) tick();
    checkOutput("t1_ack_early", ack, 8'h00);
    tick();
    checkOutput("t1_ack_rise", ack,      8'h02);
    checkOutput("t1_out_val",  out_val,  1);
    checkOutput("t1_out_data", out_data, 8'hA5);
    checkOutput("t1_out_ch",   out_ch,   1);
    checkOutput("t1_fifo_cnt", fifo_cnt, 1);
    applyStimulus(8'h00, 1'b0);
    repeat (2) tick();
    checkOutput("t1_ack_hold", ack, 8'h02);
    tick();
    checkOutput("t1_ack_fall", ack, 8'h00);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    checkOutput("t1_popped_cnt", fifo_cnt, 0);
    checkOutput("t1_popped_val", out_val,  0);

    // Simultaneous requests, two rounds.
    doReset();
    collectRound(8'h10, "t2_r1");
    collectRound(8'h20, "t2_r2");

    // Back-pressure with five requesting channels.
    doReset();
    for (int i = 0; i < 5; i++) setData(i, 8'h30 + DW'(i));
    applyStimulus(8'h1F, 1'b0);
    repeat (12) tick();
    checkOutput("t3_full_cnt", fifo_cnt, 4);
    checkOutput("t3_full_ack", ack,      8'h0F);
    checkOutput("t3_head_ch",  out_ch,   0);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    checkOutput("t3_pop_cnt",  fifo_cnt, 3);
    checkOutput("t3_pop_ack",  ack,      8'h0F);
    checkOutput("t3_pop_ch",   out_ch,   1);
    checkOutput("t3_pop_data", out_data, 8'h31);
    tick();
    checkOutput("t3_refill_cnt", fifo_cnt, 4);
    checkOutput("t3_refill_ack", ack,      8'h1F);
    applyStimulus('0, 1'b0);
    drainFifo(20);
    checkOutput("t3_drain_ch4", pop_ch_count[4], 1);

    // Push and pop in the same cycle with two entries stored.
    doReset();
    setData(0, 8'h40);
    setData(1, 8'h41);
    applyStimulus(8'h03, 1'b0);
    waitCnt(2, "t4_fill");
    setData(2, 8'h42);
    req = 8'h07;
    repeat (3) tick();
    checkOutput("t4_pre_cnt", fifo_cnt, 2);
    checkOutput("t4_pre_ack2", ack[2],  0);
    out_rdy = 1'b1;
    tick();
    checkOutput("t4_same_cnt",  fifo_cnt, 2);
    checkOutput("t4_same_ack2", ack[2],   1);
    checkOutput("t4_head1_ch",  out_ch,   1);
    checkOutput("t4_head1_dat", out_data, 8'h41);
    tick();
    checkOutput("t4_head2_cnt", fifo_cnt, 1);
    checkOutput("t4_head2_ch",  out_ch,   2);
    checkOutput("t4_head2_dat", out_data, 8'h42);
    tick();
    checkOutput("t4_empty_cnt", fifo_cnt, 0);
    out_rdy = 1'b0;

    // Reset in the middle of a handshake, with channel 2 still requesting.
    doReset();
    for (int i = 0; i < 3; i++) setData(i, 8'h50 + DW'(i));
    applyStimulus(8'h07, 1'b0);
    for (int n = 0; n < 40 && !(ack[2] && fifo_cnt == 3); n++) tick();
    checkOutput("t5_pre_ack2", ack[2],   1);
    checkOutput("t5_pre_cnt",  fifo_cnt, 3);
    rst = 1'b1;
    req = 8'h04;
    tick();
    checkOutput("t5_rst_ack",     ack,      0);
    checkOutput("t5_rst_cnt",     fifo_cnt, 0);
    checkOutput("t5_rst_out_val", out_val,  0);
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("t5_recap_early", ack[2], 0);
    tick();
    checkOutput("t5_recap_ack2", ack[2],   1);
    checkOutput("t5_recap_ch",   out_ch,   2);
    checkOutput("t5_recap_data", out_data, 8'h52);
    checkOutput("t5_recap_cnt",  fifo_cnt, 1);

    // req dropped while the channel is still PEND (FIFO full).
    doReset();
    for (int i = 1; i < 5; i++) setData(i, 8'h60 + DW'(i));
    applyStimulus(8'h1E, 1'b0);
    waitAck(8'h1E, 8'h1E, "t6_fill_ack");
    checkOutput("t6_fill_cnt", fifo_cnt, 4);
    setData(0, 8'h60);
    req = 8'h1F;
    repeat (3) tick();
    req = 8'h1E;
    repeat (5) tick();
    checkOutput("t6_ack0_low", ack[0], 0);
`ifdef REQ_ACK_RX_ERR_EN
    checkOutput("t6_err0_set", err[0], 1);
`endif
    req = 8'h00;
    drainFifo(20);
    checkOutput("t6_drain_cnt", fifo_cnt, 0);
`ifdef REQ_ACK_RX_ERR_EN
    checkOutput("t6_ch0_entries", pop_ch_count[0], 0);
    err_clr = 8'h01;
    tick();
    err_clr = 8'h00;
    checkOutput("t6_err0_clr", err[0], 0);
`else
    checkOutput("t6_ch0_entries", pop_ch_count[0], 1);
`endif
    checkOutput("t6_ack_idle", ack, 0);

    // Randomized traffic against the per-channel scoreboard.
    doReset();
    for (int i = 0; i < NCH; i++) begin
      phase[i] = 0;
      timer[i] = 0;
      exp_q[i].delete();
    end
    for (int c = 0; c < 2500; c++) randomCycle(1'b1);
    for (int c = 0; c < 400; c++) randomCycle(1'b0);
    for (int i = 0; i < NCH; i++) checkOutput("rnd_queue_empty", exp_q[i].size(), 0);
    checkOutput("rnd_final_cnt", fifo_cnt, 0);
    checkOutput("rnd_final_ack", ack,      0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
